// File: rtl/fb_arbiter_pkg.sv
// fb_pkg: default widths, packed address width and swap FSM encoding shared
// by the framebuffer arbiter and its bank-swap controller.
package fb_pkg;

  localparam int COL_W_DEF  = 6;
  localparam int ROW_W_DEF  = 4;
  localparam int DATA_W_DEF = 36;

  // {bank, row, col}
  localparam int FB_ADDR_W = 1 + ROW_W_DEF + COL_W_DEF;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

endpackage

// File: rtl/fb_arbiter_swap_ctrl.sv
// fb_swap_ctrl: front/back bank swap FSM; the swap lands only on a scan frame start.
// FB_DOUBLE_BUFFER_EN undefined: single bank, front_bank and swap_ack tied to 0.
module fb_swap_ctrl
  import fb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_swap_req,
  input  logic i_frame_start,
  output logic o_front_bank,
  output logic o_front_next,
  output logic o_swap_ack,
  output logic o_swap_pending
);

`ifdef FB_DOUBLE_BUFFER_EN
  swap_state_t r_state;
  swap_state_t w_state_next;
  logic        r_front_bank;
  logic        r_swap_ack;
  logic        w_swap;

  // A request coinciding with frame start swaps immediately instead of waiting a frame.
  always_comb begin
    w_state_next = r_state;
    w_swap       = 1'b0;
    case (r_state)
      SWAP_IDLE: begin
        if (i_swap_req) begin
          if (i_frame_start) begin
            w_swap = 1'b1;
          end else begin
            w_state_next = SWAP_PENDING;
          end
        end
      end
      SWAP_PENDING: begin
        if (i_frame_start) begin
          w_swap       = 1'b1;
          w_state_next = SWAP_IDLE;
        end
      end
      default: w_state_next = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= SWAP_IDLE;
      r_front_bank <= 1'b0;
      r_swap_ack   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_front_bank <= r_front_bank ^ w_swap;
      r_swap_ack   <= w_swap;
    end
  end

  assign o_front_bank   = r_front_bank;
  assign o_front_next   = r_front_bank ^ w_swap;
  assign o_swap_ack     = r_swap_ack;
  assign o_swap_pending = (r_state == SWAP_PENDING);
`else
  logic w_unused;
  assign w_unused = &{1'b0, i_clk, i_rst_n, i_swap_req, i_frame_start};

  assign o_front_bank   = 1'b0;
  assign o_front_next   = 1'b0;
  assign o_swap_ack     = 1'b0;
  assign o_swap_pending = 1'b0;
`endif

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: one RAM slot per cycle shared between scan reads (absolute priority)
// and host writes. FB_DOUBLE_BUFFER_EN enables front/back bank double buffering.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int COL_W  = COL_W_DEF,
  parameter int ROW_W  = ROW_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   scan_req,
  input  logic [ROW_W-1:0]       scan_row,
  input  logic [COL_W-1:0]       scan_col,
  input  logic                   scan_frame_start,
  output logic                   scan_valid,
  output logic [DATA_W-1:0]      scan_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ROW_W+COL_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   front_bank,
  output logic [ROW_W+COL_W:0]   ram_addr,
  output logic                   ram_we,
  output logic [DATA_W-1:0]      ram_wdata,
  input  logic [DATA_W-1:0]      ram_rdata
);

  localparam int RC_W = ROW_W + COL_W;

  logic              w_front_bank;
  logic              w_front_next;
  logic              w_swap_ack;
  logic              w_swap_pending;
  logic              w_wr_ready;
  logic              w_wr_fire;
  logic              w_wr_bank;

  logic              r_rd_pend;
  logic              r_scan_valid;
  logic [DATA_W-1:0] r_scan_data;
  logic              r_ram_we;
  logic [RC_W:0]     r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;

  fb_swap_ctrl u_swap_ctrl (
    .i_clk          (clk_in),
    .i_rst_n        (reset),
    .i_swap_req     (swap_req),
    .i_frame_start  (scan_frame_start),
    .o_front_bank   (w_front_bank),
    .o_front_next   (w_front_next),
    .o_swap_ack     (w_swap_ack),
    .o_swap_pending (w_swap_pending)
  );

  // Ready never looks at wr_valid, so the host sees no combinational loop.
  assign w_wr_ready = reset & ~scan_req & ~w_swap_pending;
  assign w_wr_fire  = wr_valid & w_wr_ready;

`ifdef FB_DOUBLE_BUFFER_EN
  assign w_wr_bank = ~w_front_next;
`else
  assign w_wr_bank = 1'b0;
`endif

  // Bank selection uses the post-swap value so a fetch on the swapping edge
  // already reads the new front bank.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_rd_pend    <= 1'b0;
      r_scan_valid <= 1'b0;
      r_scan_data  <= '0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
    end else begin
      r_rd_pend    <= scan_req;
      r_scan_valid <= r_rd_pend;
      if (r_rd_pend) begin
        r_scan_data <= ram_rdata;
      end
      r_ram_we <= w_wr_fire;
      if (scan_req) begin
        r_ram_addr <= {w_front_next, scan_row, scan_col};
      end else if (w_wr_fire) begin
        r_ram_addr  <= {w_wr_bank, wr_addr};
        r_ram_wdata <= wr_data;
      end
    end
  end

  assign wr_ready   = w_wr_ready;
  assign scan_valid = r_scan_valid;
  assign scan_data  = r_scan_data;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign swap_ack   = w_swap_ack;
  assign front_bank = w_front_bank;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: randomized and directed stimulus against a transaction-level
// model (bank/pending flags, shadow memory, queue of outstanding scan reads).
module tb_fb_arbiter;

  localparam int COL_W  = 6;
  localparam int ROW_W  = 4;
  localparam int DATA_W = 36;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic                   clk_in = 1'b0;
  logic                   reset;
  logic                   scan_req;
  logic [ROW_W-1:0]       scan_row;
  logic [COL_W-1:0]       scan_col;
  logic                   scan_frame_start;
  logic                   scan_valid;
  logic [DATA_W-1:0]      scan_data;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ROW_W+COL_W-1:0] wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   swap_req;
  logic                   swap_ack;
  logic                   front_bank;
  logic [ROW_W+COL_W:0]   ram_addr;
  logic                   ram_we;
  logic [DATA_W-1:0]      ram_wdata;
  logic [DATA_W-1:0]      ram_rdata;

  fb_arbiter dut (
    .clk_in           (clk_in),
    .reset            (reset),
    .scan_req         (scan_req),
    .scan_row         (scan_row),
    .scan_col         (scan_col),
    .scan_frame_start (scan_frame_start),
    .scan_valid       (scan_valid),
    .scan_data        (scan_data),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .swap_req         (swap_req),
    .swap_ack         (swap_ack),
    .front_bank       (front_bank),
    .ram_addr         (ram_addr),
    .ram_we           (ram_we),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata)
  );

  always #5 clk_in = ~clk_in;

  // Bench-owned RAM: asynchronous read, write committed at the edge after ram_we.
  logic [DATA_W-1:0] ram_mem [0:2047];
  assign ram_rdata = ram_mem[ram_addr];

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } rd_t;

  logic [DATA_W-1:0] shadow [0:2047];
  rd_t               rd_q[$];
  logic              m_front;
  logic              m_pending;
  logic              pw_v;
  logic [10:0]       pw_a;
  logic [DATA_W-1:0] pw_d;
  int                cyc;
  int                checks;
  int                errors;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_scan_valid"}, 64'(scan_valid), 64'(0));
    check({tag, "_scan_data"},  64'(scan_data),  64'(0));
    check({tag, "_ram_we"},     64'(ram_we),     64'(0));
    check({tag, "_ram_addr"},   64'(ram_addr),   64'(0));
    check({tag, "_ram_wdata"},  64'(ram_wdata),  64'(0));
    check({tag, "_swap_ack"},   64'(swap_ack),   64'(0));
    check({tag, "_front_bank"}, 64'(front_bank), 64'(0));
    check({tag, "_wr_ready"},   64'(wr_ready),   64'(0));
  endtask

  // One clock cycle: drive inputs, predict the slot, advance, compare.
  task automatic step(input logic sr, input logic [3:0] row, input logic [5:0] col,
                      input logic fs, input logic wv, input logic [9:0] wa,
                      input logic [35:0] wd, input logic sw);
    logic              exp_rdy, acc, swp, nxt_front, we_s;
    logic [10:0]       ra, wfa, a_s;
    logic [DATA_W-1:0] d_s;
    scan_req = sr; scan_row = row; scan_col = col; scan_frame_start = fs;
    wr_valid = wv; wr_addr = wa; wr_data = wd; swap_req = sw;
    #1;
    exp_rdy = !sr && !(DB && m_pending);
    check("wr_ready", 64'(wr_ready), 64'(exp_rdy));
    acc       = wv && exp_rdy;
    swp       = DB && fs && (m_pending || sw);
    nxt_front = m_front ^ swp;
    if (DB) begin
      if (swp) m_pending = 1'b0;
      else if (sw) m_pending = 1'b1;
    end
    m_front = nxt_front;
    if (pw_v) shadow[pw_a] = pw_d;
    pw_v = 1'b0;
    ra  = {nxt_front, row, col};
    wfa = {(DB ? ~nxt_front : 1'b0), wa};
    we_s = ram_we; a_s = ram_addr; d_s = ram_wdata;
    @(posedge clk_in);
    cyc++;
    if (we_s) ram_mem[a_s] = d_s;
    #1;
    check("ram_we", 64'(ram_we), 64'(acc));
    if (sr) begin
      check("rd_addr", 64'(ram_addr), 64'(ra));
      rd_q.push_back('{due: cyc + 1, data: shadow[ra]});
    end
    if (acc) begin
      check("wr_addr", 64'(ram_addr), 64'(wfa));
      check("wr_data", 64'(ram_wdata), 64'(wd));
      pw_v = 1'b1; pw_a = wfa; pw_d = wd;
      $display("txn wr addr=%03h data=%09h", wfa, wd);
    end
    check("swap_ack", 64'(swap_ack), 64'(swp));
    check("front_bank", 64'(front_bank), 64'(m_front));
    if (swp) $display("txn swap front=%0d", m_front);
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      check("scan_valid", 64'(scan_valid), 64'(1));
      check("scan_data", 64'(scan_data), 64'(rd_q[0].data));
      $display("txn rd data=%09h", rd_q[0].data);
      void'(rd_q.pop_front());
    end else begin
      check("scan_valid", 64'(scan_valid), 64'(0));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 6'd0, 1'b0, 1'b0, 10'd0, 36'd0, 1'b0);
  endtask

  task automatic reset_mid();
    reset = 1'b0; wr_valid = 1'b1; scan_req = 1'b0; swap_req = 1'b0; scan_frame_start = 1'b0;
    #1;
    check_zero("rst_mid");
    m_front = 1'b0; m_pending = 1'b0; pw_v = 1'b0; rd_q.delete();
    repeat (3) begin
      @(posedge clk_in);
      cyc++;
      #1;
      check("rst_hold_wr_ready", 64'(wr_ready), 64'(0));
      check("rst_hold_ram_we", 64'(ram_we), 64'(0));
    end
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0]       t;
    logic [DATA_W-1:0] rd;
    logic [9:0]        ra10;
    logic [3:0]        rrow;
    logic [5:0]        rcol;
    checks = 0; errors = 0; cyc = 0;
    m_front = 1'b0; m_pending = 1'b0; pw_v = 1'b0; pw_a = '0; pw_d = '0;
    reset = 1'b0; scan_req = 1'b0; scan_row = '0; scan_col = '0; scan_frame_start = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      t = {$urandom(), $urandom()};
      ram_mem[i] = t[35:0];
      shadow[i]  = t[35:0];
    end
    repeat (3) @(posedge clk_in);
    #1;
    check_zero("reset");
    reset = 1'b1;

    // Host write into the back bank
    step(1'b0, 4'd0, 6'd0, 1'b0, 1'b1, 10'h010, 36'hABC, 1'b0);
    check("tp_wr_addr", 64'(ram_addr), DB ? 64'h410 : 64'h010);

    // Scan read row 3 col 5 returning 0x123
    ram_mem[11'h0C5] = 36'h123;
    shadow[11'h0C5]  = 36'h123;
    step(1'b1, 4'd3, 6'd5, 1'b0, 1'b0, 10'd0, 36'd0, 1'b0);
    check("tp_rd_addr", 64'(ram_addr), 64'h0C5);
    idle(1);
    check("tp_rd_data", 64'(scan_data), 64'h123);

    // 64-cycle scan burst with a write held pending
    for (int i = 0; i < 64; i++)
      step(1'b1, 4'(i % 16), 6'(i), 1'b0, 1'b1, 10'h155, 36'h5A5A5A5A5, 1'b0);
    step(1'b0, 4'd0, 6'd0, 1'b0, 1'b1, 10'h155, 36'h5A5A5A5A5, 1'b0);
    idle(2);

    // Swap request, frame start 100 cycles later
    step(1'b0, 4'd0, 6'd0, 1'b0, 1'b0, 10'd0, 36'd0, 1'b1);
    for (int i = 0; i < 100; i++)
      step(1'b0, 4'd0, 6'd0, 1'b0, 1'b1, 10'(i), 36'(i * 7), 1'b0);
    step(1'b0, 4'd0, 6'd0, 1'b1, 1'b0, 10'd0, 36'd0, 1'b0);
    idle(1);

    // Same-cycle swap request and frame start with a scan fetch
    step(1'b1, 4'd0, 6'd0, 1'b1, 1'b0, 10'd0, 36'd0, 1'b1);
    idle(2);

    // Reset during a pending swap with a write in flight
    step(1'b0, 4'd0, 6'd0, 1'b0, 1'b1, 10'h3FF, 36'hFEDCBA987, 1'b1);
    reset_mid();
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      t    = {$urandom(), $urandom()};
      ra10 = 10'($urandom_range(0, 1023));
      rrow = 4'($urandom_range(0, 15));
      rcol = 6'($urandom_range(0, 63));
      rd   = t[35:0];
      step(($urandom_range(0, 99) < 45), rrow, rcol, ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 70), ra10, rd, ($urandom_range(0, 99) < 3));
    end
    idle(3);
    if (rd_q.size() != 0) check("rd_q_drained", 64'(rd_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
